// File: rtl/hreg_txn_sequencer_if.sv
// Command/response handshake bundle between a host and hreg_txn_sequencer.
// The host side uses the master modport; the sequencer uses the slave modport.
interface hreg_txn_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/hreg_txn_sequencer.sv
// Word-level sequencer driving the Hamming-protected shift register pins cycle by cycle.
// Define HREG_VERIFY_EN to add a read-back VERIFY step after LOAD and the rsp_err output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | parked (enable=0, register self-corrects), cmd_ready high
// S_LOAD   | one cycle of parallel load (or a silent busy cycle for NOP)
// S_SHIFT  | WIDTH cycles exchanging register contents with data_q
// S_RESP   | response held until rsp_ready
// S_VERIFY | read-back compare after LOAD (HREG_VERIFY_EN only)
module hreg_txn_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   hreg_txn_sequencer_if.slave txn,
   output logic               reg_enable,
   output logic [1:0]         reg_mode,
   output logic               reg_load,
   output logic               reg_serial_in,
   output logic [WIDTH-1:0]   reg_parallel_in,
   input  logic               reg_serial_out,
   input  logic [WIDTH-1:0]   reg_parallel_out,
`ifdef HREG_VERIFY_EN
   output logic               rsp_err,
`endif
   output logic               busy
);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SHIFT = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_RESP
`ifdef HREG_VERIFY_EN
      , S_VERIFY
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q;
   logic             cmd_ready_w;
`ifdef HREG_VERIFY_EN
   logic             err_q, err_d;
`endif

   // run_q keeps cmd_ready low until the first edge after reset release
   assign cmd_ready_w   = (state_q == S_IDLE) && run_q;
   assign txn.cmd_ready = cmd_ready_w;
   assign txn.rsp_valid = (state_q == S_RESP);
   assign txn.rsp_data  = rsp_data_q;
   assign busy          = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         data_q     <= '0;
         cap_q      <= '0;
         rsp_data_q <= '0;
         cnt_q      <= '0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         data_q     <= data_d;
         cap_q      <= cap_d;
         rsp_data_q <= rsp_data_d;
         cnt_q      <= cnt_d;
         run_q      <= 1'b1;
      end
   end

`ifdef HREG_VERIFY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign rsp_err = err_q;
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      data_d     = data_q;
      cap_d      = cap_q;
      rsp_data_d = rsp_data_q;
      cnt_d      = cnt_q;
`ifdef HREG_VERIFY_EN
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (txn.cmd_valid && cmd_ready_w) begin
               op_d   = txn.cmd_op;
               data_d = txn.cmd_data;
               cnt_d  = '0;
               case (txn.cmd_op)
                  OP_SHIFT: state_d = S_SHIFT;
                  OP_READ: begin
                     state_d    = S_RESP;
                     rsp_data_d = reg_parallel_out;
                  end
                  // NOP shares the LOAD slot so it shows one busy cycle with the pins gated off
                  default:  state_d = S_LOAD;
               endcase
            end
         end
         S_LOAD: begin
`ifdef HREG_VERIFY_EN
            state_d = (op_q == OP_LOAD) ? S_VERIFY : S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
         S_SHIFT: begin
            cap_d = {reg_serial_out, cap_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d    = S_RESP;
               rsp_data_d = cap_d;
               cnt_d      = '0;
            end
         end
`ifdef HREG_VERIFY_EN
         S_VERIFY: begin
            rsp_data_d = reg_parallel_out;
            err_d      = (reg_parallel_out != data_q);
            state_d    = S_RESP;
         end
`endif
         S_RESP: begin
            if (txn.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      reg_enable      = 1'b0;
      reg_mode        = 2'b11;
      reg_load        = 1'b0;
      reg_serial_in   = 1'b0;
      reg_parallel_in = '0;
      case (state_q)
         S_LOAD: begin
            if (op_q == OP_LOAD) begin
               reg_enable      = 1'b1;
               reg_load        = 1'b1;
               reg_parallel_in = data_q;
            end
         end
         S_SHIFT: begin
            reg_enable    = 1'b1;
            reg_mode      = 2'b00;
            reg_serial_in = data_q[cnt_q[IDX_W-1:0]];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hreg_txn_sequencer.sv
// Directed self-checking bench for hreg_txn_sequencer with a behavioural Hamming(12,8) register.
// Build with HREG_VERIFY_EN defined to exercise the VERIFY path.
module tb_hreg_txn_sequencer;

   logic       clk;
   logic       rst;
   logic       reg_enable;
   logic [1:0] reg_mode;
   logic       reg_load;
   logic       reg_serial_in;
   logic [7:0] reg_parallel_in;
   logic       reg_serial_out;
   logic [7:0] reg_parallel_out;
   logic       busy;
`ifdef HREG_VERIFY_EN
   logic       rsp_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0;
   int load_pulses = 0;
   int shift_cycles = 0;
   int busy_cycles = 0;

   logic [7:0] mdl_d;
   logic [3:0] mdl_c;
   logic [7:0] inj_mask;

   hreg_txn_sequencer_if #(.WIDTH(8)) txn ();

   hreg_txn_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .txn              (txn.slave),
      .reg_enable       (reg_enable),
      .reg_mode         (reg_mode),
      .reg_load         (reg_load),
      .reg_serial_in    (reg_serial_in),
      .reg_parallel_in  (reg_parallel_in),
      .reg_serial_out   (reg_serial_out),
      .reg_parallel_out (reg_parallel_out),
`ifdef HREG_VERIFY_EN
      .rsp_err          (rsp_err),
`endif
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hamming positions of data bits 0..7 in a 12-bit codeword
   function automatic int pos_of(input int j);
      case (j)
         0: return 3;
         1: return 5;
         2: return 6;
         3: return 7;
         4: return 9;
         5: return 10;
         6: return 11;
         default: return 12;
      endcase
   endfunction

   function automatic logic [3:0] ecc_gen(input logic [7:0] d);
      logic [3:0] c;
      c = '0;
      for (int j = 0; j < 8; j++)
         for (int i = 0; i < 4; i++)
            if (((pos_of(j) >> i) & 1) != 0) c[i] = c[i] ^ d[j];
      return c;
   endfunction

   function automatic logic [7:0] ecc_fix(input logic [7:0] d, input logic [3:0] c);
      logic [3:0] syn;
      logic [7:0] r;
      syn = ecc_gen(d) ^ c;
      r = d;
      for (int j = 0; j < 8; j++)
         if (syn == 4'(pos_of(j))) r[j] = ~r[j];
      return r;
   endfunction

   assign reg_parallel_out = ecc_fix(mdl_d, mdl_c);
   assign reg_serial_out   = reg_parallel_out[0];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mdl_d <= 8'h00;
         mdl_c <= 4'h0;
      end else if (inj_mask != 8'h00) begin
         mdl_d <= mdl_d ^ inj_mask;
      end else if (!reg_enable) begin
         mdl_d <= reg_parallel_out;
      end else if (reg_mode == 2'b11 && reg_load) begin
         mdl_d <= reg_parallel_in;
         mdl_c <= ecc_gen(reg_parallel_in);
      end else if (reg_mode == 2'b00) begin
         mdl_d <= {reg_serial_in, reg_parallel_out[7:1]};
         mdl_c <= ecc_gen({reg_serial_in, reg_parallel_out[7:1]});
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reg_load) load_pulses <= load_pulses + 1;
      if (reg_enable && reg_mode == 2'b00) shift_cycles <= shift_cycles + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns one ns after the accept edge, i.e. in cycle k+1
   task automatic send(input logic [1:0] op, input logic [7:0] d);
      int w;
      w = 0;
      txn.cmd_valid = 1'b1;
      txn.cmd_op    = op;
      txn.cmd_data  = d;
      while (!txn.cmd_ready && w < 50) begin
         tick();
         w++;
      end
      if (!txn.cmd_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout op=%0d cmd_ready=%b required=1", op, txn.cmd_ready);
      end
      tick();
      txn.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (!txn.cmd_ready && w < 50) begin
         tick();
         w++;
      end
      if (!txn.cmd_ready) begin
         n_checks++; n_fail++;
         $display("FAIL idle_timeout cmd_ready=%b required=1", txn.cmd_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      txn.cmd_valid = 1'b0;
      txn.cmd_op = 2'b11;
      txn.cmd_data = 8'h00;
      txn.rsp_ready = 1'b1;
      inj_mask = 8'h00;
      repeat (3) tick();
      n_checks++; if (txn.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got=%b exp=0", txn.cmd_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_checks++; if (txn.rsp_valid !== 1'b0 || txn.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp got=%b/%h exp=0/00", txn.rsp_valid, txn.rsp_data); end
      n_checks++; if ({reg_enable, reg_mode, reg_load, reg_serial_in, reg_parallel_in} !== {1'b0, 2'b11, 1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL rst_drive got=%b%b%b%b_%h exp=01100_00", reg_enable, reg_mode, reg_load, reg_serial_in, reg_parallel_in); end
      rst = 1'b1;
      #1;
      n_checks++; if (txn.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rel_cmd_ready got=%b exp=0", txn.cmd_ready); end
      tick();
      n_checks++; if (txn.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rel_cmd_ready got=%b exp=1", txn.cmd_ready); end
   endtask

   task automatic test_load_read();
      int l0;
      l0 = load_pulses;
      send(2'b00, 8'hA5);
      n_checks++; if (reg_load !== 1'b1 || reg_enable !== 1'b1 || reg_parallel_in !== 8'hA5) begin n_fail++; $display("FAIL load_drive got=%b%b_%h exp=11_a5", reg_load, reg_enable, reg_parallel_in); end
      tick();
      n_checks++; if (reg_load !== 1'b0) begin n_fail++; $display("FAIL load_end got=%b exp=0", reg_load); end
`ifndef HREG_VERIFY_EN
      n_checks++; if (txn.cmd_ready !== 1'b1 || txn.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL load_k2 ready/rsp got=%b/%b exp=1/0", txn.cmd_ready, txn.rsp_valid); end
`endif
      wait_idle();
      n_checks++; if (load_pulses - l0 !== 1) begin n_fail++; $display("FAIL load_pulse_count got=%0d exp=1", load_pulses - l0); end
      send(2'b10, 8'h00);
      n_checks++; if (txn.rsp_valid !== 1'b1 || txn.rsp_data !== 8'hA5) begin n_fail++; $display("FAIL read_a5 got=%b/%h exp=1/a5", txn.rsp_valid, txn.rsp_data); end
      wait_idle();
   endtask

   task automatic test_shift();
      int s0;
      send(2'b00, 8'h3C);
      wait_idle();
      s0 = shift_cycles;
      send(2'b01, 8'h81);
      n_checks++; if (reg_mode !== 2'b00 || reg_enable !== 1'b1 || reg_serial_in !== 1'b1) begin n_fail++; $display("FAIL shift_first got=%b/%b/%b exp=00/1/1", reg_mode, reg_enable, reg_serial_in); end
      repeat (7) tick();
      n_checks++; if (reg_mode !== 2'b00 || txn.rsp_valid !== 1'b0 || reg_serial_in !== 1'b1) begin n_fail++; $display("FAIL shift_last got=%b/%b/%b exp=00/0/1", reg_mode, txn.rsp_valid, reg_serial_in); end
      tick();
      n_checks++; if (txn.rsp_valid !== 1'b1 || txn.rsp_data !== 8'h3C) begin n_fail++; $display("FAIL shift_rsp got=%b/%h exp=1/3c", txn.rsp_valid, txn.rsp_data); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL shift_done_busy got=%b exp=0", busy); end
      n_checks++; if (shift_cycles - s0 !== 8) begin n_fail++; $display("FAIL shift_cycle_count got=%0d exp=8", shift_cycles - s0); end
      send(2'b10, 8'h00);
      n_checks++; if (txn.rsp_data !== 8'h81) begin n_fail++; $display("FAIL read_after_shift got=%h exp=81", txn.rsp_data); end
      wait_idle();
   endtask

   task automatic test_backpressure();
      txn.rsp_ready = 1'b0;
      send(2'b10, 8'h00);
      txn.cmd_valid = 1'b1;
      txn.cmd_op    = 2'b00;
      txn.cmd_data  = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (txn.rsp_valid !== 1'b1 || txn.rsp_data !== 8'h81 || txn.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/81/0", i, txn.rsp_valid, txn.rsp_data, txn.cmd_ready); end
         tick();
      end
      txn.rsp_ready = 1'b1;
      tick();
      n_checks++; if (txn.cmd_ready !== 1'b1 || txn.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b/%b exp=1/0", txn.cmd_ready, txn.rsp_valid); end
      tick();
      txn.cmd_valid = 1'b0;
      n_checks++; if (reg_load !== 1'b1 || reg_parallel_in !== 8'hFF) begin n_fail++; $display("FAIL bp_load got=%b/%h exp=1/ff", reg_load, reg_parallel_in); end
      wait_idle();
      send(2'b10, 8'h00);
      n_checks++; if (txn.rsp_data !== 8'hFF) begin n_fail++; $display("FAIL bp_read got=%h exp=ff", txn.rsp_data); end
      wait_idle();
   endtask

   task automatic test_mid_shift_reset();
      send(2'b01, 8'h33);
      repeat (3) tick();
      rst = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0 || reg_enable !== 1'b0 || txn.rsp_valid !== 1'b0 || txn.cmd_ready !== 1'b0 || reg_mode !== 2'b11) begin n_fail++; $display("FAIL midrst got=%b/%b/%b/%b/%b exp=0/0/0/0/11", busy, reg_enable, txn.rsp_valid, txn.cmd_ready, reg_mode); end
      tick();
      rst = 1'b1;
      tick();
      send(2'b10, 8'h00);
      n_checks++; if (txn.rsp_data !== 8'h00) begin n_fail++; $display("FAIL midrst_read got=%h exp=00", txn.rsp_data); end
      wait_idle();
   endtask

   task automatic test_fault();
      send(2'b00, 8'h0F);
      wait_idle();
      inj_mask = 8'h04;
      tick();
      inj_mask = 8'h00;
      n_checks++; if (reg_parallel_out !== 8'h0F) begin n_fail++; $display("FAIL fault_corrected_view got=%h exp=0f", reg_parallel_out); end
      tick();
      n_checks++; if (mdl_d !== 8'h0F) begin n_fail++; $display("FAIL fault_writeback got=%h exp=0f", mdl_d); end
      send(2'b10, 8'h00);
      n_checks++; if (txn.rsp_data !== 8'h0F) begin n_fail++; $display("FAIL fault_read got=%h exp=0f", txn.rsp_data); end
      wait_idle();
   endtask

   task automatic test_nop();
      int b0, l0;
      b0 = busy_cycles;
      l0 = load_pulses;
      send(2'b11, 8'hEE);
      n_checks++; if (busy !== 1'b1 || reg_enable !== 1'b0 || txn.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL nop_k1 got=%b/%b/%b exp=1/0/0", busy, reg_enable, txn.rsp_valid); end
      tick();
      n_checks++; if (busy !== 1'b0 || txn.cmd_ready !== 1'b1 || txn.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL nop_k2 got=%b/%b/%b exp=0/1/0", busy, txn.cmd_ready, txn.rsp_valid); end
      n_checks++; if (busy_cycles - b0 !== 1 || load_pulses - l0 !== 0) begin n_fail++; $display("FAIL nop_counts busy=%0d load=%0d exp=1/0", busy_cycles - b0, load_pulses - l0); end
      send(2'b10, 8'h00);
      n_checks++; if (txn.rsp_data !== 8'h0F) begin n_fail++; $display("FAIL nop_read got=%h exp=0f", txn.rsp_data); end
      wait_idle();
   endtask

   task automatic test_load_response();
      send(2'b00, 8'h5A);
      n_checks++; if (txn.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lr_k1 rsp_valid got=%b exp=0", txn.rsp_valid); end
      tick();
`ifdef HREG_VERIFY_EN
      n_checks++; if (txn.rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lr_k2 got=%b/%b exp=0/1", txn.rsp_valid, busy); end
      tick();
      n_checks++; if (txn.rsp_valid !== 1'b1 || txn.rsp_data !== 8'h5A || rsp_err !== 1'b0) begin n_fail++; $display("FAIL verify_rsp got=%b/%h/%b exp=1/5a/0", txn.rsp_valid, txn.rsp_data, rsp_err); end
`else
      n_checks++; if (txn.rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL lr_k2 got=%b/%b exp=0/0", txn.rsp_valid, busy); end
      tick();
      n_checks++; if (txn.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lr_k3 rsp_valid got=%b exp=0", txn.rsp_valid); end
`endif
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int t1, t2, t3;
      send(2'b01, 8'hC3);
      t1 = cyc;
      repeat (8) tick();
      n_checks++; if (txn.rsp_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_shift1 got=%h exp=5a", txn.rsp_data); end
      send(2'b01, 8'h96);
      t2 = cyc;
      n_checks++; if (t2 - t1 !== 10) begin n_fail++; $display("FAIL b2b_shift_occupancy got=%0d exp=10", t2 - t1); end
      repeat (8) tick();
      n_checks++; if (txn.rsp_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_shift2 got=%h exp=c3", txn.rsp_data); end
      send(2'b10, 8'h00);
      n_checks++; if (txn.rsp_data !== 8'h96) begin n_fail++; $display("FAIL b2b_read1 got=%h exp=96", txn.rsp_data); end
      t1 = cyc;
      send(2'b10, 8'h00);
      t3 = cyc;
      n_checks++; if (t3 - t1 !== 2) begin n_fail++; $display("FAIL b2b_read_spacing got=%0d exp=2", t3 - t1); end
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_load_read();
      test_shift();
      test_backpressure();
      test_mid_shift_reset();
      test_fault();
      test_nop();
      test_load_response();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hreg_txn_sequencer.md
# hreg_txn_sequencer

Transaction-level controller for the Hamming-protected shift register. Accepts word commands over a valid/ready interface, drives the register's `enable`/`mode`/`load`/`serial_in`/`parallel_in` pins cycle by cycle, and collects serial or parallel results into a held response. Between commands it parks the register with `enable=0` so that the register's built-in single-bit correction writes back.

## Interface
- `WIDTH`, 8: register data width, ≥4.
- `CNT_W`, 4: shift counter width, must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 2: opcode. 00 LOAD, 01 SHIFT, 10 READ, 11 NOP.
- `cmd_data` in WIDTH: LOAD word, or SHIFT word to insert.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out WIDTH: READ word, or the word displaced by SHIFT.
- `reg_enable` out 1: drives register `enable`.
- `reg_mode` out 2: drives register `mode`.
- `reg_load` out 1: drives register `load`.
- `reg_serial_in` out 1: drives register `serial_in`.
- `reg_parallel_in` out WIDTH: drives register `parallel_in`.
- `reg_serial_out` in 1: from register `serial_out`.
- `reg_parallel_out` in WIDTH: from register `parallel_out`. This value is already corrected.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, LOAD, SHIFT, RESP, plus VERIFY (only with `HREG_VERIFY_EN` defined).
- **Idle drive** (IDLE, RESP, VERIFY): `reg_enable=0`, `reg_mode=11`, `reg_load=0`, `reg_serial_in=0`, `reg_parallel_in=0`. The register holds its value and self-corrects.
- **Accept rule:**
  - `cmd_ready=1` only in IDLE.
  - A command is accepted on a clock edge with `cmd_valid & cmd_ready`.
  - On accept, `cmd_op` and `cmd_data` are latched into `op_q` and `data_q`.
- **LOAD:**
  - One cycle driving `reg_enable=1`, `reg_mode=11`, `reg_load=1`, `reg_parallel_in=data_q`.
  - Next state is IDLE, or VERIFY when the feature is enabled.
  - LOAD produces no response.
- **SHIFT:** exchanges the register contents with `data_q`, LSB-first.
  - Runs for WIDTH cycles with `reg_enable=1`, `reg_mode=00`, `reg_serial_in=data_q[cnt]`, where `cnt` counts 0..WIDTH-1.
  - On each SHIFT edge the sequencer captures `cap <= {reg_serial_out, cap[WIDTH-1:1]}`.
  - After WIDTH cycles the register holds `data_q` and `cap` holds the old word.
  - Next state is RESP with `rsp_data=cap`.
- **READ:** goes from the accept edge straight to RESP, with `rsp_data` = `reg_parallel_out` sampled on the accept edge.
- **NOP:** accepted; returns to IDLE with no register activity.
- **RESP:**
  - `rsp_valid=1` and `rsp_data` stay stable until an edge with `rsp_ready=1`.
  - Then the state returns to IDLE.
  - `rsp_ready` outside RESP is ignored.
- **Reset (any time, including mid-SHIFT):**
  - State goes to IDLE; `cnt`, `cap`, `data_q`, `op_q` all clear to 0.
  - `rsp_valid=0`, `rsp_data=0`, `busy=0`, idle drive on all `reg_*` outputs.
  - `cmd_ready` rises at the first cycle after `rst` deasserts; it is 0 while `rst` is low.

## Timing
Cycle counts below are from the accept edge *k*; *n* is the first RESP cycle.
- **LOAD:** LOAD state in cycle k+1; register updated at edge k+2; `cmd_ready=1` in cycle k+2.
- **SHIFT:**
  - SHIFT state in cycles k+1 .. k+WIDTH.
  - `rsp_valid=1` from cycle k+WIDTH+1.
  - Minimum occupancy is WIDTH+2 cycles with `rsp_ready` tied high.
- **READ:** `rsp_valid=1` in cycle k+1.
- **Response handshake:** if `rsp_ready=1` during RESP cycle *n*, the state is IDLE in cycle n+1. Back-to-back commands therefore have one idle cycle between them.
- **Command outside IDLE:** `cmd_valid` asserted while not in IDLE is held off by `cmd_ready=0`. `cmd_op`/`cmd_data` must then be held stable until accepted.
- **Output type:** all outputs are registered state or decoded purely from state, `cnt` and `data_q`. No combinational path exists from `cmd_*` or `reg_*` inputs to outputs.

## Configuration
- **`HREG_VERIFY_EN` defined:**
  - After LOAD, the VERIFY state runs for one idle-drive cycle, compares `reg_parallel_out` with `data_q`, then goes to RESP.
  - RESP carries `rsp_data=reg_parallel_out`.
  - An extra output `rsp_err` (1 bit) is 1 when the compared values differ. It is valid with `rsp_valid` and resets to 0.
  - LOAD then costs 3 cycles plus the response handshake.
- **`HREG_VERIFY_EN` undefined:** no VERIFY state, no `rsp_err` port, and LOAD returns no response.

## Test plan
- **Reset then LOAD:**
  - Stimulus: reset, then LOAD 0xA5, then READ.
  - Required response: `reg_load` pulses for exactly 1 cycle; READ `rsp_data=0xA5`, with `rsp_valid` in the cycle after accept.
- **SHIFT exchange:**
  - Stimulus: LOAD 0x3C, then SHIFT `cmd_data=0x81`, `rsp_ready` high.
  - Required response: `reg_mode=00` for exactly 8 cycles; `rsp_data=0x3C` at cycle k+9; a following READ returns 0x81.
- **Response back-pressure:**
  - Stimulus: READ with `rsp_ready=0` for 5 cycles, and `cmd_valid` held with LOAD 0xFF.
  - Required response: `rsp_valid` and `rsp_data` stable; `cmd_ready=0` throughout; LOAD accepted 1 cycle after `rsp_ready` rises.
- **Mid-SHIFT reset:**
  - Stimulus: assert `rst` at cycle k+4 of a SHIFT.
  - Required response: `busy=0`, `reg_enable=0`, `rsp_valid=0` immediately; a READ after release returns 0x00.
- **Injected fault:**
  - Stimulus: LOAD 0x0F, then force register bit 2 flipped while in IDLE.
  - Required response: READ returns 0x0F, and an internal register probe shows the corrected value one cycle later.
- **NOP and verify:**
  - Stimulus: NOP; separately LOAD 0x5A (with `HREG_VERIFY_EN`).
  - Required response: NOP gives `busy` for 1 cycle and no response; LOAD 0x5A gives `rsp_valid` at cycle k+3 with `rsp_err=0`, `rsp_data=0x5A`.
